// File: rtl/pipe_pkg.sv
// Purpose: shared definitions for the write-back tag pipeline.
//   - Default register-address and stall-counter widths.
//   - The write-back tag layout {reg_write, mem_read, write_addr}.
//   - The bubble tag. It is all-zero, so any stage register that loads '0
//     holds a bubble.
// Ports: none (package).
package pipe_pkg;

  localparam int REG_AW_DFLT = 6;
  localparam int CNT_W_DFLT  = 16;

  typedef struct packed {
    logic                   reg_write;
    logic                   mem_read;
    logic [REG_AW_DFLT-1:0] write_addr;
  } tag_t;

  localparam tag_t BUBBLE_TAG = '{reg_write: 1'b0, mem_read: 1'b0, write_addr: '0};

endpackage

// File: rtl/wb_tag_stage.sv
// Purpose: one pipeline tag register.
//   - Asynchronous active-low clear.
//   - Enable: when low, the register holds its contents.
//   - Bubble load: when enabled, loads the all-zero bubble encoding instead of d_i.
// Ports:
//   clk_i, rst_n_i  clock / async active-low reset
//   en_i            advance this stage (low = freeze)
//   bubble_i        load a bubble instead of d_i
//   d_i             next tag (packed fields)
//   q_o             registered tag
module wb_tag_stage
  import pipe_pkg::*;
#(
  parameter int W = $bits(tag_t)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] tag_q;
  logic [W-1:0] tag_d;

  always_comb begin
    tag_d = tag_q;
    if (en_i) begin
      tag_d = bubble_i ? '0 : d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign q_o = tag_q;

endmodule

// File: rtl/wb_tag_pipe.sv
// Purpose: carries destination tags and write-back controls through the
// ID/EX, EX/MEM and MEM/WB latches.
//   - Feeds the forward unit from these latches.
//   - Detects load-use hazards and inserts the bubble.
//   - Generates the PC and IF/ID hold signals.
//   - Counts load-use stall cycles with a saturating counter.
// Ports:
//   clk_i, rst_n_i          clock / async active-low reset
//   hold_i                  global freeze; every register keeps its value
//   flush_i                 discard the instruction in ID (bubble into ID/EX)
//   id_*_i                  ID-stage sources, destination and control flags
//   IDEX_RsAddr_o/RtAddr_o  ID/EX source addresses to the forward unit
//   EXMEM_WB_o/WriteAddr_o  EX/MEM RegWrite and destination
//   MEMWB_WB_o/WriteAddr_o  MEM/WB RegWrite and destination
//   PCWrite_o, IFIDWrite_o  0 = hold PC / IF-ID
//   hazard_o                load-use stall this cycle (combinational)
//   stall_cnt_o             saturating count of load-use stall edges
module wb_tag_pipe
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DFLT,
  parameter int CNT_W  = CNT_W_DFLT
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] id_RsAddr_i,
  input  logic [REG_AW-1:0] id_RtAddr_i,
  input  logic [REG_AW-1:0] id_WriteAddr_i,
  input  logic              id_RegWrite_i,
  input  logic              id_MemRead_i,
  input  logic              id_UsesRt_i,
  output logic [REG_AW-1:0] IDEX_RsAddr_o,
  output logic [REG_AW-1:0] IDEX_RtAddr_o,
  output logic              EXMEM_WB_o,
  output logic [REG_AW-1:0] EXMEM_WriteAddr_o,
  output logic              MEMWB_WB_o,
  output logic [REG_AW-1:0] MEMWB_WriteAddr_o,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
  output logic              hazard_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // ID/EX layout: {rs, rt, mem_read, reg_write, write_addr}.
  localparam int IDEX_W = 3 * REG_AW + 2;
  // MemRead only matters in ID/EX, where it drives the hazard check.
  // Past ID/EX it has no consumer, so later stages carry {reg_write, write_addr}.
  localparam int WB_W   = REG_AW + 1;

  logic              stage_en;
  logic [IDEX_W-1:0] idex_d;
  logic [IDEX_W-1:0] idex_q;
  logic [WB_W-1:0]   exmem_q;
  logic [WB_W-1:0]   memwb_q;

  logic              idex_mem_read;
  logic              idex_reg_write;
  logic [REG_AW-1:0] idex_write_addr;

  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  assign stage_en = ~hold_i;
  assign idex_d   = {id_RsAddr_i, id_RtAddr_i, id_MemRead_i, id_RegWrite_i, id_WriteAddr_i};

  assign {IDEX_RsAddr_o, IDEX_RtAddr_o, idex_mem_read, idex_reg_write, idex_write_addr} = idex_q;
  assign {EXMEM_WB_o, EXMEM_WriteAddr_o} = exmem_q;
  assign {MEMWB_WB_o, MEMWB_WriteAddr_o} = memwb_q;

  // Load-use hazard: the load in EX writes a register that the ID instruction
  // reads. Rt counts only when the ID instruction uses it. Destination 0 never stalls.
  assign hazard_o = idex_mem_read && (idex_write_addr != '0) &&
                    ((idex_write_addr == id_RsAddr_i) ||
                     (id_UsesRt_i && (idex_write_addr == id_RtAddr_i)));

  assign PCWrite_o   = ~(hazard_o | hold_i);
  assign IFIDWrite_o = ~(hazard_o | hold_i);

  wb_tag_stage #(.W(IDEX_W)) u_idex (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .en_i     (stage_en),
    .bubble_i (hazard_o | flush_i),
    .d_i      (idex_d),
    .q_o      (idex_q)
  );

  wb_tag_stage #(.W(WB_W)) u_exmem (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .en_i     (stage_en),
    .bubble_i (1'b0),
    .d_i      ({idex_reg_write, idex_write_addr}),
    .q_o      (exmem_q)
  );

  wb_tag_stage #(.W(WB_W)) u_memwb (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .en_i     (stage_en),
    .bubble_i (1'b0),
    .d_i      (exmem_q),
    .q_o      (memwb_q)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard_o && !hold_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_wb_tag_pipe.sv
module tb_wb_tag_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       hold_i = 1'b0;
  logic       flush_i = 1'b0;
  logic [5:0] rs_i = '0, rt_i = '0, wa_i = '0;
  logic       rw_i = 1'b0, mr_i = 1'b0, ut_i = 1'b0;

  logic [5:0]  d_rs, d_rt, d_exwa, d_mwwa;
  logic        d_exwb, d_mwwb, d_pcw, d_ifw, d_haz;
  logic [15:0] d_cnt;
  logic [5:0]  s_rs, s_rt, s_exwa, s_mwwa;
  logic        s_exwb, s_mwwb, s_pcw, s_ifw, s_haz;
  logic [1:0]  s_cnt;

  wb_tag_pipe u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .hold_i(hold_i), .flush_i(flush_i),
    .id_RsAddr_i(rs_i), .id_RtAddr_i(rt_i), .id_WriteAddr_i(wa_i),
    .id_RegWrite_i(rw_i), .id_MemRead_i(mr_i), .id_UsesRt_i(ut_i),
    .IDEX_RsAddr_o(d_rs), .IDEX_RtAddr_o(d_rt),
    .EXMEM_WB_o(d_exwb), .EXMEM_WriteAddr_o(d_exwa),
    .MEMWB_WB_o(d_mwwb), .MEMWB_WriteAddr_o(d_mwwa),
    .PCWrite_o(d_pcw), .IFIDWrite_o(d_ifw), .hazard_o(d_haz), .stall_cnt_o(d_cnt)
  );

  // Same stimulus, 2-bit counter, to see saturation quickly.
  wb_tag_pipe #(.CNT_W(2)) u_sat (
    .clk_i(clk), .rst_n_i(rst_n), .hold_i(hold_i), .flush_i(flush_i),
    .id_RsAddr_i(rs_i), .id_RtAddr_i(rt_i), .id_WriteAddr_i(wa_i),
    .id_RegWrite_i(rw_i), .id_MemRead_i(mr_i), .id_UsesRt_i(ut_i),
    .IDEX_RsAddr_o(s_rs), .IDEX_RtAddr_o(s_rt),
    .EXMEM_WB_o(s_exwb), .EXMEM_WriteAddr_o(s_exwa),
    .MEMWB_WB_o(s_mwwb), .MEMWB_WriteAddr_o(s_mwwa),
    .PCWrite_o(s_pcw), .IFIDWrite_o(s_ifw), .hazard_o(s_haz), .stall_cnt_o(s_cnt)
  );

  // ---------------- reference model ----------------
  // A pipeline slot is the instruction accepted into ID/EX on some edge.
  // pipe_q[0] is in ID/EX, pipe_q[1] in EX/MEM and pipe_q[2] in MEM/WB.
  typedef struct packed {
    logic       rw;
    logic       mr;
    logic [5:0] wa;
    logic [5:0] rs;
    logic [5:0] rt;
  } ent_t;

  typedef struct packed {
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic        exwb;
    logic [5:0]  exwa;
    logic        mwwb;
    logic [5:0]  mwwa;
    logic        pcw;
    logic        ifw;
    logic        haz;
    logic [15:0] cnt;
    logic [1:0]  scnt;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  ent_t pipe_q[$];
  int   stall_total;

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  function automatic logic model_hazard();
    ent_t ld;
    ld = pipe_q[0];
    return ld.mr && (ld.wa != 0) && ((ld.wa == rs_i) || (ut_i && (ld.wa == rt_i)));
  endfunction

  task automatic model_reset();
    pipe_q.delete();
    for (int i = 0; i < 3; i++) pipe_q.push_back('0);
    stall_total = 0;
  endtask

  // Apply one cycle's inputs at posedge+1. The model first advances over the
  // edge just taken, using the inputs that were applied during that edge.
  task automatic step(input logic rst, input logic hd, input logic fl,
                      input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] wa,
                      input logic rw, input logic mr, input logic ut);
    ent_t n;
    exp_t e;
    logic hz;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n && !hold_i) begin
      hz = model_hazard();
      if (hz) stall_total++;
      n = (hz || flush_i) ? '0 : '{rw: rw_i, mr: mr_i, wa: wa_i, rs: rs_i, rt: rt_i};
      void'(pipe_q.pop_back());
      pipe_q.push_front(n);
    end
    rst_n = rst; hold_i = hd; flush_i = fl;
    rs_i = rs; rt_i = rt; wa_i = wa; rw_i = rw; mr_i = mr; ut_i = ut;
    if (!rst) model_reset();
    hz     = model_hazard();
    e.rs   = pipe_q[0].rs;
    e.rt   = pipe_q[0].rt;
    e.exwb = pipe_q[1].rw;
    e.exwa = pipe_q[1].wa;
    e.mwwb = pipe_q[2].rw;
    e.mwwa = pipe_q[2].wa;
    e.haz  = hz;
    e.pcw  = !(hz || hd);
    e.ifw  = !(hz || hd);
    e.cnt  = 16'((stall_total > 65535) ? 65535 : stall_total);
    e.scnt = 2'((stall_total > 3) ? 3 : stall_total);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle in which the driver has issued a vector, compare mid-cycle.
  exp_t m_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_t'(exp_q.pop_front());
      n_vec++;
      chk("idex_rs",    16'(d_rs),   16'(m_e.rs));
      chk("idex_rt",    16'(d_rt),   16'(m_e.rt));
      chk("exmem_wb",   16'(d_exwb), 16'(m_e.exwb));
      chk("exmem_wa",   16'(d_exwa), 16'(m_e.exwa));
      chk("memwb_wb",   16'(d_mwwb), 16'(m_e.mwwb));
      chk("memwb_wa",   16'(d_mwwa), 16'(m_e.mwwa));
      chk("pcwrite",    16'(d_pcw),  16'(m_e.pcw));
      chk("ifidwrite",  16'(d_ifw),  16'(m_e.ifw));
      chk("hazard",     16'(d_haz),  16'(m_e.haz));
      chk("stall_cnt",  d_cnt,       m_e.cnt);
      chk("sat_rs",     16'(s_rs),   16'(m_e.rs));
      chk("sat_rt",     16'(s_rt),   16'(m_e.rt));
      chk("sat_exmem",  16'({s_exwb, s_exwa}), 16'({m_e.exwb, m_e.exwa}));
      chk("sat_memwb",  16'({s_mwwb, s_mwwa}), 16'({m_e.mwwb, m_e.mwwa}));
      chk("sat_ctl",    16'({s_pcw, s_ifw, s_haz}), 16'({m_e.pcw, m_e.ifw, m_e.haz}));
      chk("sat_cnt",    16'(s_cnt),  16'(m_e.scnt));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    // Reset held, then released.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Load-use on Rs: lw $5, then a consumer of $5 (stalled once, then accepted).
    step(1, 0, 0, 1, 2, 5, 1, 1, 0);
    step(1, 0, 0, 5, 3, 6, 1, 0, 1);
    step(1, 0, 0, 5, 3, 6, 1, 0, 1);
    idle(3);

    // Rt counts only when used.
    step(1, 0, 0, 1, 2, 7, 1, 1, 0);
    step(1, 0, 0, 3, 7, 8, 1, 0, 0);
    idle(2);
    step(1, 0, 0, 1, 2, 7, 1, 1, 0);
    step(1, 0, 0, 3, 7, 8, 1, 0, 1);
    step(1, 0, 0, 3, 7, 8, 1, 0, 1);
    idle(3);

    // Destination 0: no hazard, tag still travels to MEM/WB.
    step(1, 0, 0, 1, 2, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 4, 1, 0, 0);
    idle(3);

    // Hold for 3 cycles with a hazard pending.
    step(1, 0, 0, 1, 2, 5, 1, 1, 0);
    step(1, 1, 0, 5, 3, 6, 1, 0, 1);
    step(1, 1, 1, 5, 3, 6, 1, 0, 1);
    step(1, 1, 0, 5, 3, 6, 1, 0, 1);
    step(1, 0, 0, 5, 3, 6, 1, 0, 1);
    step(1, 0, 0, 5, 3, 6, 1, 0, 1);
    idle(3);

    // Flush of an add to $9.
    step(1, 0, 1, 1, 2, 9, 1, 0, 0);
    idle(3);

    // Hazard and flush together.
    step(1, 0, 0, 1, 2, 3, 1, 1, 0);
    step(1, 0, 1, 3, 4, 10, 1, 0, 1);
    idle(3);

    // Five more load-use stalls: 2-bit counter saturates.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1, 2, 11, 1, 1, 0);
      step(1, 0, 0, 11, 2, 12, 1, 0, 0);
      step(1, 0, 0, 11, 2, 12, 1, 0, 0);
    end
    idle(2);

    // Reset mid-operation drops in-flight tags.
    step(1, 0, 0, 1, 2, 13, 1, 0, 0);
    step(1, 0, 0, 1, 2, 14, 1, 1, 0);
    step(0, 0, 0, 14, 2, 15, 1, 0, 0);
    idle(3);

    // Randomised traffic; small address range so hazards are frequent.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0),
           6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end
    idle(3);

    // Drain the scoreboard, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
